regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:

---
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter: each requester feeds a one-entry buffer, and an age-aware
// round-robin arbiter drains the buffers into a registered register-file write port.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p0_valid,
    output logic                 p0_ready,
    input  logic [ADDR_W-1:0]    p0_reg,
    input  logic [DATA_W-1:0]    p0_data,
    input  logic                 p1_valid,
    output logic                 p1_ready,
    input  logic [ADDR_W-1:0]    p1_reg,
    input  logic [DATA_W-1:0]    p1_data,
    output logic                 write_enable,
    output logic [ADDR_W-1:0]    write_reg,
    output logic [DATA_W-1:0]    write_data,
    output logic [2**ADDR_W-1:0] pending_mask
);

    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [ADDR_W-1:0] in_reg  [2];
    logic [DATA_W-1:0] in_data [2];

    logic [1:0]        buf_full;
    logic [ADDR_W-1:0] buf_reg  [2];
    logic [DATA_W-1:0] buf_data [2];
    logic              p1_older;
    logic              rr_ptr;

    logic [1:0]        grant;
    logic              rr_flip;
    logic [1:0]        fill;

    assign in_valid   = {p1_valid, p0_valid};
    assign in_reg[0]  = p0_reg;
    assign in_reg[1]  = p1_reg;
    assign in_data[0] = p0_data;
    assign in_data[1] = p1_data;
    assign p0_ready   = in_ready[0];
    assign p1_ready   = in_ready[1];

    // Same-register conflicts are resolved by age so the later value lands last in the file.
    always_comb begin
        grant   = 2'b00;
        rr_flip = 1'b0;
        if (buf_full == 2'b11) begin
            if (buf_reg[0] == buf_reg[1]) begin
                grant = p1_older ? 2'b10 : 2'b01;
            end else if (FIXED_PRIO) begin
                grant = 2'b01;
            end else begin
                grant   = rr_ptr ? 2'b10 : 2'b01;
                rr_flip = 1'b1;
            end
        end else begin
            grant = buf_full;
        end
    end

    // Writes to register 0 are handshaken but never buffered.
    always_comb begin
        in_ready = 2'b00;
        fill     = 2'b00;
        for (int k = 0; k < 2; k++) begin
            in_ready[k] = reset & (~buf_full[k] | grant[k]);
            fill[k]     = in_valid[k] & in_ready[k] & (in_reg[k] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                buf_reg[k]  <= '0;
                buf_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (fill[k]) begin
                    buf_full[k] <= 1'b1;
                    buf_reg[k]  <= in_reg[k];
                    buf_data[k] <= in_data[k];
                end else if (grant[k]) begin
                    buf_full[k] <= 1'b0;
                end
            end
        end
    end

    // p1_older marks buffer 1 as holding the earlier-filled entry; a simultaneous fill favours port 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_older <= 1'b0;
            rr_ptr   <= 1'b0;
        end else begin
            if (fill == 2'b11) begin
                p1_older <= 1'b0;
            end else if (fill[0] && buf_full[1] && !grant[1]) begin
                p1_older <= 1'b1;
            end else if (fill[1] && buf_full[0] && !grant[0]) begin
                p1_older <= 1'b0;
            end
            if (rr_flip) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= |grant;
            if (grant[1]) begin
                write_reg  <= buf_reg[1];
                write_data <= buf_data[1];
            end else if (grant[0]) begin
                write_reg  <= buf_reg[0];
                write_data <= buf_data[0];
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int k = 0; k < 2; k++) begin
            if (buf_full[k]) begin
                pending_mask[buf_reg[k]] = 1'b1;
            end
        end
        if (write_enable) begin
            pending_mask[write_reg] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: a round-robin instance (dut_a) and a
// fixed-priority instance (dut_b) share the same request inputs.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        p0_valid, p1_valid;
    logic [4:0]  p0_reg, p1_reg;
    logic [31:0] p0_data, p1_data;

    logic        a_p0_ready, a_p1_ready, a_we;
    logic [4:0]  a_wreg;
    logic [31:0] a_wdata, a_pend;
    logic        b_p0_ready, b_p1_ready, b_we;
    logic [4:0]  b_wreg;
    logic [31:0] b_wdata, b_pend;

    wr_t wr_a[$];
    wr_t wr_b[$];
    int  checks = 0;
    int  passed = 0;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(a_p0_ready), .p0_reg(p0_reg), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(a_p1_ready), .p1_reg(p1_reg), .p1_data(p1_data),
        .write_enable(a_we), .write_reg(a_wreg), .write_data(a_wdata), .pending_mask(a_pend)
    );

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(b_p0_ready), .p0_reg(p0_reg), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(b_p1_ready), .p1_reg(p1_reg), .p1_data(p1_data),
        .write_enable(b_we), .write_reg(b_wreg), .write_data(b_wdata), .pending_mask(b_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every register-file write each instance performs, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_we === 1'b1) wr_a.push_back({a_wreg, a_wdata});
        if (b_we === 1'b1) wr_b.push_back({b_wreg, b_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        p0_valid = 1'b0; p0_reg = '0; p0_data = '0;
        p1_valid = 1'b0; p1_reg = '0; p1_data = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wr_a.delete();
        wr_b.delete();
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #2;
        checks++; if (a_we !== 1'b0) $display("[TB] FAIL reset_we: got %b expected 0", a_we); else passed++;
        checks++; if (a_wreg !== 5'd0) $display("[TB] FAIL reset_wreg: got %0d expected 0", a_wreg); else passed++;
        checks++; if (a_wdata !== 32'h0) $display("[TB] FAIL reset_wdata: got %h expected 0", a_wdata); else passed++;
        checks++; if (a_pend !== 32'h0) $display("[TB] FAIL reset_pend: got %h expected 0", a_pend); else passed++;
        checks++; if ({a_p0_ready, a_p1_ready, b_p0_ready, b_p1_ready} !== 4'b0000)
            $display("[TB] FAIL reset_ready: got %b expected 0000", {a_p0_ready, a_p1_ready, b_p0_ready, b_p1_ready}); else passed++;
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if ({a_p0_ready, a_p1_ready} !== 2'b11)
            $display("[TB] FAIL release_ready: got %b expected 11", {a_p0_ready, a_p1_ready}); else passed++;
    endtask

    task automatic test_single_write();
        apply_reset();
        p0_valid = 1'b1; p0_reg = 5'd5; p0_data = 32'hDEADBEEF;
        checks++; if (a_pend !== 32'h0) $display("[TB] FAIL single_pend0: got %h expected 0", a_pend); else passed++;
        tick();
        drive_idle();
        checks++; if (a_we !== 1'b0) $display("[TB] FAIL single_we1: got %b expected 0", a_we); else passed++;
        checks++; if (a_pend !== 32'h20) $display("[TB] FAIL single_pend1: got %h expected 00000020", a_pend); else passed++;
        tick();
        checks++; if ({a_we, a_wreg, a_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("[TB] FAIL single_write: got we=%b reg=%0d data=%h expected we=1 reg=5 data=deadbeef", a_we, a_wreg, a_wdata); else passed++;
        checks++; if (a_pend !== 32'h20) $display("[TB] FAIL single_pend2: got %h expected 00000020", a_pend); else passed++;
        tick();
        checks++; if ({a_we, a_wreg} !== {1'b0, 5'd5}) $display("[TB] FAIL single_after: got we=%b reg=%0d expected we=0 reg=5", a_we, a_wreg); else passed++;
        checks++; if (a_pend !== 32'h0) $display("[TB] FAIL single_pend3: got %h expected 0", a_pend); else passed++;
    endtask

    task automatic test_round_robin();
        int i0, i1, w0, w1, cyc, wcount;
        logic f0, f1;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        apply_reset();
        i0 = 0; i1 = 0; w0 = 0; w1 = 0; cyc = 0; wcount = 0;
        p0_valid = 1'b1; p0_reg = 5'd1; p0_data = 32'h1000_0000;
        p1_valid = 1'b1; p1_reg = 5'd2; p1_data = 32'h2000_0000;
        while (wcount < 100 && cyc < 300) begin
            f0 = p0_valid & a_p0_ready;
            f1 = p1_valid & a_p1_ready;
            tick();
            cyc++;
            if (f0) i0++;
            if (f1) i1++;
            p0_data = 32'h1000_0000 + i0;
            p1_data = 32'h2000_0000 + i1;
            checks++; if ({a_p0_ready, a_p1_ready} !== {cyc % 2 == 1, cyc % 2 == 0})
                $display("[TB] FAIL rr_ready cyc %0d: got %b expected %b", cyc, {a_p0_ready, a_p1_ready}, {cyc % 2 == 1, cyc % 2 == 0}); else passed++;
            if (a_we === 1'b1) begin
                exp_reg  = (wcount % 2 == 0) ? 5'd1 : 5'd2;
                exp_data = (exp_reg == 5'd1) ? 32'h1000_0000 + w0 : 32'h2000_0000 + w1;
                checks++; if ({a_wreg, a_wdata} !== {exp_reg, exp_data})
                    $display("[TB] FAIL rr_write %0d: got reg=%0d data=%h expected reg=%0d data=%h", wcount, a_wreg, a_wdata, exp_reg, exp_data); else passed++;
                if (a_wreg == 5'd1) w0++; else if (a_wreg == 5'd2) w1++;
                wcount++;
            end
        end
        checks++; if (wcount < 100) $display("[TB] FAIL rr_timeout: got %0d writes expected 100", wcount); else passed++;
        drive_idle();
        repeat (4) begin
            tick();
            if (a_we === 1'b1) begin
                exp_reg  = (wcount % 2 == 0) ? 5'd1 : 5'd2;
                exp_data = (exp_reg == 5'd1) ? 32'h1000_0000 + w0 : 32'h2000_0000 + w1;
                checks++; if ({a_wreg, a_wdata} !== {exp_reg, exp_data})
                    $display("[TB] FAIL rr_drain %0d: got reg=%0d data=%h expected reg=%0d data=%h", wcount, a_wreg, a_wdata, exp_reg, exp_data); else passed++;
                if (a_wreg == 5'd1) w0++; else if (a_wreg == 5'd2) w1++;
                wcount++;
            end
        end
        checks++; if (w0 !== i0 || w1 !== i1)
            $display("[TB] FAIL rr_count: got writes %0d/%0d expected %0d/%0d", w0, w1, i0, i1); else passed++;
    endtask

    task automatic test_same_reg_order();
        // Round-robin instance: leave the pointer favouring port 1, then collide on r7.
        apply_reset();
        p0_valid = 1'b1; p0_reg = 5'd1; p0_data = 32'h11;
        p1_valid = 1'b1; p1_reg = 5'd2; p1_data = 32'h22;
        tick();
        drive_idle();
        repeat (3) tick();
        p0_valid = 1'b1; p0_reg = 5'd7; p0_data = 32'h1;
        p1_valid = 1'b1; p1_reg = 5'd7; p1_data = 32'h2;
        tick();
        drive_idle();
        repeat (4) tick();
        checks++; if (wr_a.size() != 4) $display("[TB] FAIL same_edge_count: got %0d expected 4", wr_a.size()); else passed++;
        if (wr_a.size() == 4) begin
            checks++; if (wr_a[0] !== {5'd1, 32'h11} || wr_a[1] !== {5'd2, 32'h22})
                $display("[TB] FAIL same_edge_pre: got %h %h expected r1=11 r2=22", wr_a[0], wr_a[1]); else passed++;
            checks++; if (wr_a[2] !== {5'd7, 32'h1}) $display("[TB] FAIL same_edge_first: got %h expected r7=1", wr_a[2]); else passed++;
            checks++; if (wr_a[3] !== {5'd7, 32'h2}) $display("[TB] FAIL same_edge_final: got %h expected r7=2", wr_a[3]); else passed++;
        end
        // Fixed-priority instance: p1 r9 waits behind p0, then an older p1 beats the newer p0 on r9.
        apply_reset();
        p0_valid = 1'b1; p0_reg = 5'd3; p0_data = 32'h3;
        p1_valid = 1'b1; p1_reg = 5'd9; p1_data = 32'hA;
        tick();
        p1_valid = 1'b0;
        p0_reg = 5'd9; p0_data = 32'hB;
        tick();
        drive_idle();
        repeat (4) tick();
        checks++; if (wr_b.size() != 3) $display("[TB] FAIL age_count: got %0d expected 3", wr_b.size()); else passed++;
        if (wr_b.size() == 3) begin
            checks++; if (wr_b[0] !== {5'd3, 32'h3}) $display("[TB] FAIL age_first: got %h expected r3=3", wr_b[0]); else passed++;
            checks++; if (wr_b[1] !== {5'd9, 32'hA} || wr_b[2] !== {5'd9, 32'hB})
                $display("[TB] FAIL age_order: got %h %h expected r9=A then r9=B", wr_b[1], wr_b[2]); else passed++;
        end
    endtask

    task automatic test_reg_zero();
        apply_reset();
        p1_valid = 1'b1; p1_reg = 5'd0; p1_data = 32'h1234;
        checks++; if (a_p1_ready !== 1'b1) $display("[TB] FAIL zero_ready0: got %b expected 1", a_p1_ready); else passed++;
        tick();
        checks++; if ({a_p1_ready, a_we} !== 2'b10) $display("[TB] FAIL zero_ready1: got ready=%b we=%b expected ready=1 we=0", a_p1_ready, a_we); else passed++;
        checks++; if (a_pend !== 32'h0) $display("[TB] FAIL zero_pend: got %h expected 0", a_pend); else passed++;
        p1_reg = 5'd4; p1_data = 32'h55;
        tick();
        p1_valid = 1'b0;
        checks++; if (a_we !== 1'b0) $display("[TB] FAIL zero_no_write: got %b expected 0", a_we); else passed++;
        checks++; if (a_pend !== 32'h10) $display("[TB] FAIL zero_next_pend: got %h expected 00000010", a_pend); else passed++;
        tick();
        checks++; if ({a_we, a_wreg, a_wdata} !== {1'b1, 5'd4, 32'h55})
            $display("[TB] FAIL zero_next_write: got we=%b reg=%0d data=%h expected we=1 reg=4 data=55", a_we, a_wreg, a_wdata); else passed++;
        tick();
        checks++; if (wr_a.size() != 1) $display("[TB] FAIL zero_write_count: got %0d expected 1", wr_a.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        p0_valid = 1'b1; p0_reg = 5'd1; p0_data = 32'h1;
        p1_valid = 1'b1; p1_reg = 5'd2; p1_data = 32'h2;
        tick();
        p1_valid = 1'b0;
        p0_reg = 5'd3; p0_data = 32'h3;
        tick();
        drive_idle();
        checks++; if ({a_we, a_pend} !== {1'b1, 32'h0000_000E})
            $display("[TB] FAIL mid_setup: got we=%b pend=%h expected we=1 pend=0000000e", a_we, a_pend); else passed++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({a_we, a_wreg, a_wdata, a_pend} !== {1'b0, 5'd0, 32'h0, 32'h0})
            $display("[TB] FAIL mid_clear: got we=%b reg=%0d data=%h pend=%h expected all 0", a_we, a_wreg, a_wdata, a_pend); else passed++;
        checks++; if ({a_p0_ready, a_p1_ready} !== 2'b00) $display("[TB] FAIL mid_ready_low: got %b expected 00", {a_p0_ready, a_p1_ready}); else passed++;
        wr_a.delete();
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if ({a_p0_ready, a_p1_ready} !== 2'b11) $display("[TB] FAIL mid_ready_high: got %b expected 11", {a_p0_ready, a_p1_ready}); else passed++;
        repeat (4) tick();
        checks++; if (wr_a.size() != 0) $display("[TB] FAIL mid_dropped: got %0d writes expected 0", wr_a.size()); else passed++;
    endtask

    task automatic test_starvation();
        int a_r2, b_r1;
        logic back_to_back_r1;
        apply_reset();
        p0_valid = 1'b1; p0_reg = 5'd1; p0_data = 32'h100;
        p1_valid = 1'b1; p1_reg = 5'd2; p1_data = 32'h200;
        repeat (20) tick();
        @(negedge clk);
        #1;
        a_r2 = 0; b_r1 = 0; back_to_back_r1 = 1'b0;
        foreach (wr_a[i]) if (wr_a[i].r == 5'd2) a_r2++;
        for (int i = 0; i + 1 < wr_a.size(); i++)
            if (wr_a[i].r == 5'd1 && wr_a[i+1].r == 5'd1) back_to_back_r1 = 1'b1;
        foreach (wr_b[i]) if (wr_b[i].r == 5'd1) b_r1++;
        checks++; if (wr_a.size() != 19 || a_r2 != 9)
            $display("[TB] FAIL rr_share: got %0d writes %0d to r2 expected 19 writes 9 to r2", wr_a.size(), a_r2); else passed++;
        checks++; if (back_to_back_r1) $display("[TB] FAIL rr_starve: got consecutive p0 grants expected alternation"); else passed++;
        checks++; if (wr_b.size() != 19 || b_r1 != 19)
            $display("[TB] FAIL fixed_prio: got %0d writes %0d to r1 expected 19 writes 19 to r1", wr_b.size(), b_r1); else passed++;
        p0_valid = 1'b0;
        repeat (3) tick();
        p1_valid = 1'b0;
        repeat (3) tick();
        checks++; if (wr_b.size() < 21 || wr_b[19].r != 5'd1 || wr_b[20].r != 5'd2)
            $display("[TB] FAIL fixed_idle_grant: got %0d writes expected p1 granted once p0 idles", wr_b.size()); else passed++;
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single_write();
        test_round_robin();
        test_same_reg_order();
        test_reg_zero();
        test_reset_mid();
        test_starvation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
